controle_micro: RTL
===================

# controle_micro

Cooking-cycle controller for the microwave timer. It sequences the time-entry stage: it enables the keypad and shifts each accepted digit into a 4-digit BCD mm:ss register. It then runs the cook cycle, decrementing once per 1 Hz edge, and handles start, stop, door and done conditions. It drives the magnetron enable and the four BCD digits consumed by the display stage.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- resetn  in  1  reset: one clock; reset is asynchronous and active-low.
- D  in  4  digit from the keypad priority encoder; values above 9 are ignored.
- loadn  in  1  keypad level from the time-entry stage; high while any key is held.
- pgt_1Hz  in  1  1 Hz square wave from the time-entry stage; asynchronous to clk.
- startn  in  1  start button, active-low level.
- stopn  in  1  stop/clear button, active-low level.
- door_closed  in  1  high while the door is closed.
- enablen  out  1  keypad enable to the time-entry stage; low means entry is allowed.
- mag_on  out  1  magnetron enable.
- done  out  1  cycle-complete indicator.
- min_tens, min_units, sec_tens, sec_units  out  4 each  BCD time register.

## Operation
Input conditioning:
- loadn, pgt_1Hz, startn, stopn and door_closed each pass through a 2-flop synchronizer.
- The synchronizer output feeds an edge-detect register.
- Events derived from the conditioned inputs:
  - key = rising edge of loadn
  - tick = rising edge of pgt_1Hz
  - start = falling edge of startn
  - stop = falling edge of stopn
  - door = synchronized door_closed level
- Each event is a single-cycle pulse.

States:
- IDLE: enablen=0, mag_on=0, done=0.
  - key with D≤9: shift left. min_tens←min_units, min_units←sec_tens, sec_tens←sec_units, sec_units←D.
  - stop: all digits ←0.
  - start with door=1 and time≠00:00: go to COOK.
  - start with time=00:00 or door=0: ignored.
- COOK: enablen=1, mag_on=1.
  - tick: decrement mm:ss in BCD. sec_units borrows 0→9, sec_tens borrows 0→5, min_units borrows 0→9, min_tens decrements.
  - If the decremented value is 00:00, go to DONE on the same edge.
  - stop or door=0: go to PAUSE; digits hold.
- PAUSE: enablen=1, mag_on=0.
  - start with door=1: go to COOK.
  - stop: all digits ←0, go to IDLE.
  - tick and key: ignored.
- DONE: enablen=1, mag_on=0, done=1, digits read 00:00.
  - start, stop or key: go to IDLE with done=0. The triggering key is not loaded.

Arithmetic rules:
- Entered seconds above 59 (for example 0:75) are accepted.
- Countdown from such values proceeds literally (75, 74, …). The 0→5 borrow applies only when sec_tens is 0.

Event priority within one cycle, highest first: stop, door=0, start, key, tick.
- stop and tick together in COOK: go to PAUSE with no decrement.
- start and key together in IDLE: the state goes to COOK and the key is dropped.

## Timing
- Reset, while resetn=0 and asynchronously: state IDLE, all digits 0, enablen=0, mag_on=0, done=0.
- Reset values of the synchronizer and edge registers: startn/stopn paths 1, loadn/pgt_1Hz paths 0, door path 0.
- Reset asserted mid-COOK drops mag_on immediately, without waiting for clk.
- Event latency: an input transition sampled at rising edge k produces its event, and the resulting register and output update, at edge k+3. Outputs are registered.
- Inputs must hold for at least 3 clk cycles. A held button or key produces exactly one event.
- Decrement happens once per pgt_1Hz rising edge, 3 cycles after sampling. No decrement occurs on the tick that coincides with the COOK entry edge.
- The 00:00 check uses the post-decrement value. mag_on falls on the same edge that sets done.

## Test plan
- Reset, then key events 1, 2, 3 → 01:23 shown. A fourth key 4 → 12:34. D=12 → no change.
- 00:05 loaded, start with door closed → mag_on=1 after 3 cycles. Exactly 5 ticks → 00:00, done=1, mag_on=0. Then stop → IDLE, enablen=0.
- 01:00 in COOK, one tick → 00:59. 10:00, one tick → 09:59.
- COOK at 00:30, door opens → PAUSE, mag_on=0, 00:30 held through ticks. Door closes, start → COOK resumes from 00:30. stop in PAUSE → 00:00, IDLE.
- stop and tick in the same cycle in COOK → PAUSE, no decrement. start at 00:00 → remains IDLE.
- resetn pulsed low mid-COOK at 02:10 → mag_on=0 asynchronously, digits 0, IDLE.

Source files
------------

// File: rtl/controle_micro.sv
// Microwave cooking-cycle controller: conditions the front-panel inputs, shifts keypad
// digits into an mm:ss BCD register and runs the cook / pause / done sequence.
module controle_micro (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic       mag_on,
  output logic       done,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units
);

  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

  // Bit order: {door_closed, stopn, startn, pgt_1Hz, loadn}; button paths idle high.
  localparam logic [4:0] SYNC_RST = 5'b01100;

  logic [4:0]  sync1_q, sync2_q, edge_q;
  logic [3:0]  ev_q, ev_d;
  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic        enablen_q, mag_q, done_q;
  logic        key, tick, start, stop, door;

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Edge pulses are registered so every event lands three edges after sampling.
  always_comb begin
    ev_d    = '0;
    ev_d[0] =  sync2_q[0] & ~edge_q[0];
    ev_d[1] =  sync2_q[1] & ~edge_q[1];
    ev_d[2] = ~sync2_q[2] &  edge_q[2];
    ev_d[3] = ~sync2_q[3] &  edge_q[3];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      edge_q  <= SYNC_RST;
      ev_q    <= '0;
    end else begin
      sync1_q <= {door_closed, stopn, startn, pgt_1Hz, loadn};
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      ev_q    <= ev_d;
    end
  end

  assign key   = ev_q[0];
  assign tick  = ev_q[1];
  assign start = ev_q[2];
  assign stop  = ev_q[3];
  assign door  = edge_q[4];

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    case (state_q)
      IDLE: begin
        if (stop) time_d = '0;
        else if (start && door && time_q != 16'h0000) state_d = COOK;
        else if (key && D <= 4'd9) time_d = {time_q[11:0], D};
      end
      COOK: begin
        if (stop || !door) state_d = PAUSE;
        else if (tick) begin
          time_d = bcd_dec(time_q);
          if (time_d == 16'h0000) state_d = DONE;
        end
      end
      PAUSE: begin
        if (stop) begin
          time_d  = '0;
          state_d = IDLE;
        end else if (start && door) state_d = COOK;
      end
      DONE: begin
        time_d = '0;
        if (stop || start || key) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      time_q    <= '0;
      enablen_q <= 1'b0;
      mag_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      enablen_q <= (state_d != IDLE);
      mag_q     <= (state_d == COOK);
      done_q    <= (state_d == DONE);
    end
  end

  assign enablen   = enablen_q;
  assign mag_on    = mag_q;
  assign done      = done_q;
  assign min_tens  = time_q[15:12];
  assign min_units = time_q[11:8];
  assign sec_tens  = time_q[7:4];
  assign sec_units = time_q[3:0];

endmodule
